// File: rtl/pconv_feeder.sv
`default_nettype none
// ============================================================================
// pconv_feeder : frame/weight buffer and beat sequencer for the pointwise
//                convolution unit (one beat per (oc, pixel), idle cycle between)
// Revision     : 1.0
// ============================================================================
module pconv_feeder #(
    parameter int N              = 16,
    parameter int INPUT_CHANNEL  = 3,
    parameter int OUTPUT_CHANNEL = 4,
    parameter int INPUT_SIZE     = 8,
    localparam int P   = INPUT_SIZE * INPUT_SIZE,
    localparam int OCW = (OUTPUT_CHANNEL > 1) ? $clog2(OUTPUT_CHANNEL) : 1,
    localparam int PW  = (P > 1) ? $clog2(P) : 1,
    localparam int VW  = INPUT_CHANNEL * N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pix_wr_en,
    input  logic [VW-1:0]  pix_wr_din,
    input  logic           wt_wr_en,
    input  logic [OCW-1:0] wt_wr_addr,
    input  logic [VW-1:0]  wt_wr_din,
    input  logic [31:0]    bias_wr_din,
    input  logic [4:0]     shift_wr_din,
    input  logic           start,
    input  logic           stall,
    output logic           ce,
    output logic           input_vld,
    output logic [VW-1:0]  input_din,
    output logic [VW-1:0]  weight_din,
    output logic [31:0]    bias_din,
    output logic [4:0]     shift_din,
    output logic [OCW-1:0] oc_idx,
    output logic [PW-1:0]  pix_idx,
    output logic           frame_rdy,
    output logic           busy,
    output logic           done
);

    localparam logic [PW-1:0]  PIX_LAST = PW'(P - 1);
    localparam logic [OCW-1:0] OC_LAST  = OCW'(OUTPUT_CHANNEL - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BEAT = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic           frame_rdy_q, frame_rdy_d;
    logic [OCW-1:0] oc_q, oc_d;
    logic [PW-1:0]  pix_q, pix_d;
    logic           last_q, last_d;

    logic           vld_q, ce_q, done_q;
    logic [VW-1:0]  din_q, wdin_q;
    logic [31:0]    bias_q;
    logic [4:0]     shift_q;
    logic [OCW-1:0] oc_idx_q;
    logic [PW-1:0]  pix_idx_q;

    logic [VW-1:0]  pix_mem   [P];
    logic [VW-1:0]  wt_mem    [OUTPUT_CHANNEL];
    logic [31:0]    bias_mem  [OUTPUT_CHANNEL];
    logic [4:0]     shift_mem [OUTPUT_CHANNEL];

    logic w_beat, w_pix_we, w_wt_we;

    assign w_beat   = (state_q == S_BEAT) && !stall;
    assign w_pix_we = pix_wr_en && (state_q == S_IDLE);
    assign w_wt_we  = wt_wr_en && (state_q == S_IDLE) && (int'(wt_wr_addr) < OUTPUT_CHANNEL);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        frame_rdy_d = frame_rdy_q;
        oc_d        = oc_q;
        pix_d       = pix_q;
        last_d      = last_q;
        case (state_q)
            S_IDLE: begin
                if (w_pix_we) begin
                    if (wr_ptr_q == PIX_LAST) begin
                        wr_ptr_d    = '0;
                        frame_rdy_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PW'(1);
                    end
                end
                if (start && frame_rdy_q) begin
                    state_d = S_BEAT;
                    oc_d    = '0;
                    pix_d   = '0;
                    last_d  = 1'b0;
                end
            end
            S_BEAT: begin
                if (!stall) begin
                    state_d = S_GAP;
                    if (pix_q == PIX_LAST) begin
                        pix_d = '0;
                        if (oc_q == OC_LAST) last_d = 1'b1;
                        else                 oc_d   = oc_q + OCW'(1);
                    end else begin
                        pix_d = pix_q + PW'(1);
                    end
                end
            end
            S_GAP: begin
                if (!stall) state_d = last_q ? S_DONE : S_BEAT;
            end
            S_DONE: begin
                // A completed run consumes the frame; the next run needs a fresh load.
                state_d     = S_IDLE;
                frame_rdy_d = 1'b0;
                wr_ptr_d    = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            frame_rdy_q <= 1'b0;
            oc_q        <= '0;
            pix_q       <= '0;
            last_q      <= 1'b0;
            vld_q       <= 1'b0;
            ce_q        <= 1'b0;
            done_q      <= 1'b0;
            din_q       <= '0;
            wdin_q      <= '0;
            bias_q      <= '0;
            shift_q     <= '0;
            oc_idx_q    <= '0;
            pix_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            frame_rdy_q <= frame_rdy_d;
            oc_q        <= oc_d;
            pix_q       <= pix_d;
            last_q      <= last_d;
            vld_q       <= w_beat;
            ce_q        <= (state_d != S_IDLE) && !stall;
            done_q      <= (state_q == S_DONE);
            // Beat data is held between beats and cleared once the run ends.
            if (w_beat) begin
                din_q     <= pix_mem[pix_q];
                wdin_q    <= wt_mem[oc_q];
                bias_q    <= bias_mem[oc_q];
                shift_q   <= shift_mem[oc_q];
                oc_idx_q  <= oc_q;
                pix_idx_q <= pix_q;
            end else if (state_d == S_IDLE) begin
                din_q     <= '0;
                wdin_q    <= '0;
                bias_q    <= '0;
                shift_q   <= '0;
                oc_idx_q  <= '0;
                pix_idx_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_pix_we) pix_mem[wr_ptr_q] <= pix_wr_din;
        if (w_wt_we) begin
            wt_mem[wt_wr_addr]    <= wt_wr_din;
            bias_mem[wt_wr_addr]  <= bias_wr_din;
            shift_mem[wt_wr_addr] <= shift_wr_din;
        end
    end

    assign ce         = ce_q;
    assign input_vld  = vld_q;
    assign input_din  = din_q;
    assign weight_din = wdin_q;
    assign bias_din   = bias_q;
    assign shift_din  = shift_q;
    assign oc_idx     = oc_idx_q;
    assign pix_idx    = pix_idx_q;
    assign frame_rdy  = frame_rdy_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pconv_feeder.sv
`default_nettype none
// ============================================================================
// tb_pconv_feeder : directed self-checking bench, 2 output channels, 2x2 frame
// Revision        : 1.0
// ============================================================================
module tb_pconv_feeder;

    localparam int N  = 16;
    localparam int IC = 3;
    localparam int OC = 2;
    localparam int IS = 2;
    localparam int P  = IS * IS;
    localparam int K  = OC * P;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_wr_en, wt_wr_en, start, stall;
    logic [47:0] pix_wr_din, wt_wr_din;
    logic [0:0]  wt_wr_addr;
    logic [31:0] bias_wr_din;
    logic [4:0]  shift_wr_din;
    logic        ce, input_vld, frame_rdy, busy, done;
    logic [47:0] input_din, weight_din;
    logic [31:0] bias_din;
    logic [4:0]  shift_din;
    logic [0:0]  oc_idx;
    logic [1:0]  pix_idx;

    int n_checks = 0;
    int n_errors = 0;

    pconv_feeder #(.N(N), .INPUT_CHANNEL(IC), .OUTPUT_CHANNEL(OC), .INPUT_SIZE(IS)) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_wr_en(pix_wr_en), .pix_wr_din(pix_wr_din),
        .wt_wr_en(wt_wr_en), .wt_wr_addr(wt_wr_addr), .wt_wr_din(wt_wr_din),
        .bias_wr_din(bias_wr_din), .shift_wr_din(shift_wr_din),
        .start(start), .stall(stall),
        .ce(ce), .input_vld(input_vld), .input_din(input_din), .weight_din(weight_din),
        .bias_din(bias_din), .shift_din(shift_din), .oc_idx(oc_idx), .pix_idx(pix_idx),
        .frame_rdy(frame_rdy), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] pv(input int p);
        logic [15:0] v;
        v = 16'(p + 1);
        return {v + 16'h0300, v + 16'h0200, v + 16'h0100};
    endfunction
    function automatic logic [47:0] wv(input int oc);
        logic [15:0] v;
        v = 16'(oc);
        return {v + 16'hC300, v + 16'hC200, v + 16'hC100};
    endfunction
    function automatic logic [31:0] bv(input int oc);
        return 32'hB000_0000 + 32'(oc * 17 + 5);
    endfunction
    function automatic logic [4:0] sv(input int oc);
        return 5'(7 + oc * 9);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_data(input string tag, input bit zero, input int oc, input int pix);
        chk({tag, " din"},   64'(input_din),  zero ? 64'd0 : 64'(pv(pix)));
        chk({tag, " wgt"},   64'(weight_din), zero ? 64'd0 : 64'(wv(oc)));
        chk({tag, " bias"},  64'(bias_din),   zero ? 64'd0 : 64'(bv(oc)));
        chk({tag, " shift"}, 64'(shift_din),  zero ? 64'd0 : 64'(sv(oc)));
        chk({tag, " oc"},    64'(oc_idx),     zero ? 64'd0 : 64'(oc));
        chk({tag, " pix"},   64'(pix_idx),    zero ? 64'd0 : 64'(pix));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " vld"},   64'(input_vld), 64'd0);
        chk({tag, " ce"},    64'(ce),        64'd0);
        chk({tag, " busy"},  64'(busy),      64'd0);
        chk({tag, " done"},  64'(done),      64'd0);
        chk({tag, " frdy"},  64'(frame_rdy), 64'd0);
        chk_data(tag, 1'b1, 0, 0);
    endtask

    task automatic load_pix(input int p);
        pix_wr_en = 1'b1; pix_wr_din = pv(p);
        step;
        pix_wr_en = 1'b0;
    endtask

    task automatic load_wt(input int oc);
        wt_wr_en = 1'b1; wt_wr_addr = 1'(oc);
        wt_wr_din = wv(oc); bias_wr_din = bv(oc); shift_wr_din = sv(oc);
        step;
        wt_wr_en = 1'b0;
    endtask

    task automatic clear_inputs;
        start = 1'b0; stall = 1'b0; pix_wr_en = 1'b0; wt_wr_en = 1'b0;
    endtask

    // Edge (counted from the start edge) at which beat j appears; stall cycles
    // before beat s push it and all later beats back by L.
    function automatic int beat_at(input int c, input int s, input int L);
        for (int j = 0; j < K; j++)
            if (c == 1 + 2 * j + ((s >= 0 && j >= s) ? L : 0)) return j;
        return -1;
    endfunction

    task automatic run_check(input string name, input int s, input int L,
                             input bit disturb, input int abort_beat);
        int  dedge, last_j, j;
        bit  stall_now, zero;
        string tg;
        dedge  = 2 * K + 1 + ((s >= 0) ? L : 0);
        last_j = -1;
        for (int c = 1; c <= dedge; c++) begin
            stall_now    = (s >= 0) && (c - 1 >= 2 * s) && (c - 1 < 2 * s + L);
            stall        = stall_now;
            start        = disturb && (c == 4 || c == dedge);
            pix_wr_en    = disturb && (c == 6);
            pix_wr_din   = 48'hDEAD_BEEF_0BAD;
            wt_wr_en     = disturb && (c == 8);
            wt_wr_addr   = 1'b0;
            wt_wr_din    = 48'h1111_2222_3333;
            bias_wr_din  = 32'hFFFF_FFFF;
            shift_wr_din = 5'd31;
            step;
            tg = $sformatf("%s c%0d", name, c);
            j  = beat_at(c, s, L);
            chk({tg, " vld"},  64'(input_vld), 64'(j >= 0));
            chk({tg, " ce"},   64'(ce),        64'((c < dedge) && !stall_now));
            chk({tg, " busy"}, 64'(busy),      64'(c < dedge));
            chk({tg, " done"}, 64'(done),      64'(c == dedge));
            chk({tg, " frdy"}, 64'(frame_rdy), 64'(c < dedge));
            if (j >= 0) last_j = j;
            zero = (c == dedge) || (last_j < 0);
            chk_data(tg, zero, (last_j < 0) ? 0 : last_j / P, (last_j < 0) ? 0 : last_j % P);
            if (abort_beat >= 0 && j == abort_beat) begin
                clear_inputs();
                #1 rst_n = 1'b0;
                #1 chk_zero({name, " async-reset"});
                #1 rst_n = 1'b1;
                return;
            end
        end
        clear_inputs();
        start = disturb;
        step;
        start = 1'b0;
        chk_zero({name, " after"});
    endtask

    task automatic load_frame;
        for (int p = 0; p < P; p++) load_pix(p);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        clear_inputs();
        pix_wr_din = '0; wt_wr_din = '0; wt_wr_addr = '0; bias_wr_din = '0; shift_wr_din = '0;
        #2 rst_n = 1'b0;
        #1 chk_zero("reset");
        step; step;
        rst_n = 1'b1;
        step;
        chk_zero("post-reset");

        // Partial frame: start must be ignored.
        load_wt(0);
        load_wt(1);
        for (int p = 0; p < P - 1; p++) load_pix(p);
        chk("partial frdy", 64'(frame_rdy), 64'd0);
        pulse_start();
        chk("partial busy", 64'(busy), 64'd0);
        step;
        chk("partial vld", 64'(input_vld), 64'd0);
        chk("partial busy2", 64'(busy), 64'd0);
        load_pix(P - 1);
        chk("full frdy", 64'(frame_rdy), 64'd1);

        pulse_start();
        run_check("run1", -1, 0, 1'b0, -1);

        load_frame();
        pulse_start();
        run_check("stall", 2, 3, 1'b0, -1);

        // Stall alongside start, plus writes and starts during the run.
        load_frame();
        stall = 1'b1;
        pulse_start();
        chk("stallstart busy", 64'(busy), 64'd1);
        chk("stallstart ce", 64'(ce), 64'd0);
        run_check("disturb", -1, 0, 1'b1, -1);

        load_frame();
        pulse_start();
        run_check("abort", -1, 0, 1'b0, 5);
        pulse_start();
        chk("abort restart busy", 64'(busy), 64'd0);

        load_wt(0);
        load_wt(1);
        load_frame();
        pulse_start();
        run_check("rerun", -1, 0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pconv_feeder.md
# pconv_feeder

Sequencer that drives the pointwise-convolution unit. It buffers one input frame of packed channel vectors and one weight/bias/shift set per output channel. On `start` it streams every (output channel, pixel) pair as single-cycle `input_vld` beats. Each beat is followed by a mandatory idle cycle, so the downstream per-beat accumulator clears between results.

## Interface
- N, 16, data bit width of one channel element
- INPUT_CHANNEL, 3, channels packed per beat
- OUTPUT_CHANNEL, 4, number of weight sets / output channels
- INPUT_SIZE, 8, frame side length; frame holds INPUT_SIZE*INPUT_SIZE pixels (P)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pix_wr_en  in  1  write one pixel vector at internal write pointer
- pix_wr_din  in  INPUT_CHANNEL*N  pixel vector, channel i at bits [(i+1)*N-1:i*N]
- wt_wr_en  in  1  write weight set at wt_wr_addr
- wt_wr_addr  in  $clog2(OUTPUT_CHANNEL)  output-channel index
- wt_wr_din  in  INPUT_CHANNEL*N  weight vector, same packing
- bias_wr_din  in  32  bias for that output channel
- shift_wr_din  in  5  shift for that output channel
- start  in  1  begin streaming; pulse
- stall  in  1  freeze sequencing while high
- ce  out  1  downstream enable, = ~stall while busy, 0 otherwise (registered)
- input_vld  out  1  beat valid (registered)
- input_din  out  INPUT_CHANNEL*N  pixel vector of current beat
- weight_din  out  INPUT_CHANNEL*N  weight vector of current output channel
- bias_din  out  32  bias of current output channel
- shift_din  out  5  shift of current output channel
- oc_idx  out  $clog2(OUTPUT_CHANNEL)  output channel of current beat
- pix_idx  out  $clog2(P)  pixel index of current beat
- frame_rdy  out  1  full frame loaded, run allowed
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run

## Operation
- Reset: all outputs 0, FSM IDLE, write pointer 0, frame_rdy 0. Buffer and weight contents are undefined.
- Pixel load (IDLE only): pix_wr_en stores the vector at the pointer and increments it. At P-1 the pointer wraps to 0 and sets frame_rdy. Further writes overwrite from pixel 0, and frame_rdy stays 1.
- Weight load (IDLE only): wt_wr_en stores weight, bias and shift at wt_wr_addr. An address ≥ OUTPUT_CHANNEL is ignored.
- Writes while busy are ignored entirely.
- FSM states: IDLE, BEAT, GAP, DONE.
  - IDLE→BEAT: start & frame_rdy. Start without frame_rdy, or start while busy, is ignored.
  - BEAT→GAP when stall=0. BEAT holds while stall=1.
  - GAP→BEAT when stall=0 and beats remain.
  - GAP→DONE when stall=0 after the last beat.
  - DONE→IDLE unconditionally. Exiting DONE clears frame_rdy and resets the write pointer.
- Order: oc_idx outer (0..OUTPUT_CHANNEL-1), pix_idx inner (0..P-1). Total K = OUTPUT_CHANNEL*P beats.
- input_vld is 1 only in BEAT with stall=0. It is never high on two consecutive cycles.
- Data outputs (input_din, weight_din, bias_din, shift_din, oc_idx, pix_idx) become valid with each beat. They are held stable until the next beat and return to 0 in IDLE.
- busy is high in BEAT, GAP and DONE.

## Timing
- start sampled high at edge t (IDLE, frame_rdy=1). The first beat is visible in the cycle after edge t+1.
- Without stall, beats occupy every second cycle: beat j is visible after edge t+1+2j.
- done is high for exactly one cycle, following the GAP of beat K-1. busy falls with done.
- Unstalled run: start to done = 2K+1 edges.
- Each cycle with stall high in BEAT/GAP adds exactly one cycle and emits no beat.
- A stall high in the same cycle as start does not block acceptance.
- rst_n low mid-run: immediate return to IDLE with outputs 0; the frame must be reloaded.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately; frame_rdy=0.
- INPUT_SIZE=2, OUTPUT_CHANNEL=2, pixels 1..4, weights oc0/oc1 distinct, start -> 8 beats spaced 2 cycles. Order (oc,pix) = (0,0)..(0,3),(1,0)..(1,3) with matching din/weight/bias/shift. done 17 edges after start.
- start with only 3 of 4 pixels loaded -> no busy, no beats. Load the 4th pixel, start -> run proceeds.
- stall high for 3 cycles during beat 2 -> beat 2 is delayed by 3 cycles, ce=0 during the stall, no duplicated beat, done delayed by 3.
- start and pix_wr_en/wt_wr_en during a run -> ignored; outputs identical to an undisturbed run. frame_rdy=0 after done.
- rst_n low at beat 5 -> outputs 0. Reload the frame, start -> full 8-beat run from (0,0).
